// File: rtl/timer_dev_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_dev_pkg
//  Description : Shared definitions for the bus-mapped countdown timer:
//                FSM state encoding, register word offsets, CTRL bit
//                positions and Mode codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_dev_pkg;

    // Timer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    // Register word offsets (PrAddr[3:2])
    localparam logic [1:0] C_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] C_ADDR_PRESET = 2'd1;
    localparam logic [1:0] C_ADDR_COUNT  = 2'd2;

    // CTRL field positions
    localparam int C_CTRL_EN_BIT   = 0;
    localparam int C_CTRL_MODE_LSB = 1;
    localparam int C_CTRL_MODE_MSB = 2;
    localparam int C_CTRL_IM_BIT   = 3;
    localparam int C_CTRL_W        = 4;

    // Mode codes; any code other than auto-reload behaves as one-shot
    localparam logic [1:0] C_MODE_ONESHOT = 2'b00;
    localparam logic [1:0] C_MODE_AUTO    = 2'b01;

    // True when the CTRL value selects auto-reload operation
    function automatic logic is_auto_reload(input logic [C_CTRL_W-1:0] ctrl);
        return (ctrl[C_CTRL_MODE_MSB:C_CTRL_MODE_LSB] == C_MODE_AUTO);
    endfunction

endpackage : timer_dev_pkg
`default_nettype wire

// File: rtl/timer_dev.sv
`default_nettype none
// ============================================================================
//  Module      : timer_dev
//  Description : Bus-mapped 32-bit countdown timer with one-shot and
//                auto-reload modes and a maskable interrupt request.
//                Registers: CTRL (word 0), PRESET (word 1), COUNT (word 2,
//                read-only). Address decode is done by the system bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_dev
    import timer_dev_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    state_e              state_q, state_d;
    logic [C_CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]         preset_q, preset_d;
    logic [31:0]         count_q, count_d;
    logic                irq_flag_q, irq_flag_d;

    logic w_enable;
    logic w_wr_ctrl;
    logic w_wr_preset;

    assign w_enable    = ctrl_q[C_CTRL_EN_BIT];
    assign w_wr_ctrl   = WE && (Addr == C_ADDR_CTRL);
    assign w_wr_preset = WE && (Addr == C_ADDR_PRESET);

    // State and register file, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // Next-state logic: IDLE -> LOAD -> CNT -> INT -> (LOAD | IDLE)
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_enable) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!w_enable) begin
                    state_d = ST_IDLE;
                end else if (count_q <= 32'd1) begin
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                state_d = is_auto_reload(ctrl_q) ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State actions on COUNT/irq_flag/Enable; bus writes are applied last so
    // they win over any FSM update made on the same edge
    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            ST_LOAD: begin
                count_d = preset_q;
            end
            ST_CNT: begin
                if (w_enable) begin
                    if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        // PRESET=0 lands here too, so COUNT never wraps
                        count_d    = '0;
                        irq_flag_d = 1'b1;
                    end
                end
            end
            ST_INT: begin
                if (is_auto_reload(ctrl_q)) begin
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d[C_CTRL_EN_BIT] = 1'b0;
                end
            end
            default: begin
            end
        endcase

        if (w_wr_ctrl) begin
            ctrl_d     = DIn[C_CTRL_W-1:0];
            irq_flag_d = 1'b0;
        end
        if (w_wr_preset) begin
            preset_d   = DIn;
            irq_flag_d = 1'b0;
        end
    end

    // Combinational bus read mux and masked interrupt output
    always_comb begin
        DOut = '0;
        case (Addr)
            C_ADDR_CTRL:   DOut = {{(32-C_CTRL_W){1'b0}}, ctrl_q};
            C_ADDR_PRESET: DOut = preset_q;
            C_ADDR_COUNT:  DOut = count_q;
            default:       DOut = '0;
        endcase
        IRQ = irq_flag_q && ctrl_q[C_CTRL_IM_BIT];
    end

endmodule : timer_dev
`default_nettype wire

// File: tb/tb_timer_dev.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_dev
//  Description : Directed self-checking bench for timer_dev with
//                hand-computed expected register and IRQ values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_dev;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic [1:0]  Addr = 2'd0;
    logic        WE   = 1'b0;
    logic [31:0] DIn  = 32'd0;
    logic [31:0] DOut;
    logic        IRQ;

    int checks   = 0;
    int failures = 0;

    timer_dev u_dut (
        .clk  (clk),
        .rst  (rst),
        .Addr (Addr),
        .WE   (WE),
        .DIn  (DIn),
        .DOut (DOut),
        .IRQ  (IRQ)
    );

    always #10 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Write lands on the next rising edge; returns 1 ns after that edge
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = a;
        DIn  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check_eq(tag, DOut, exp);
    endtask

    task automatic check_irq(input string tag, input logic exp);
        check_eq(tag, {31'd0, IRQ}, {31'd0, exp});
    endtask

    logic [31:0] ar_count [4] = '{32'd2, 32'd1, 32'd0, 32'd0};
    logic        ar_irq   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        // ---------------- Reset ----------------
        #3;
        check_reg("rst_ctrl", 2'd0, 32'd0);
        check_reg("rst_preset", 2'd1, 32'd0);
        check_reg("rst_count", 2'd2, 32'd0);
        check_irq("rst_irq", 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        ticks(3);
        check_reg("post_rst_ctrl", 2'd0, 32'd0);
        check_reg("post_rst_count", 2'd2, 32'd0);

        // Writes to COUNT / reserved are ignored
        bus_write(2'd2, 32'h55);
        check_reg("wr_count_ignored", 2'd2, 32'd0);
        bus_write(2'd3, 32'hAA);
        check_reg("rsvd_reads_zero", 2'd3, 32'd0);

        // ---------------- One-shot, PRESET=3 ----------------
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'h9);                 // edge N
        tick();                                 // N+1
        for (int k = 3; k >= 1; k--) begin      // N+2..N+4
            tick();
            check_reg("os_count", 2'd2, 32'(k));
            check_irq("os_irq_low", 1'b0);
        end
        tick();                                 // N+5
        check_reg("os_count_zero", 2'd2, 32'd0);
        check_irq("os_irq_rise", 1'b1);
        tick();                                 // N+6: Enable cleared
        check_reg("os_en_cleared", 2'd0, 32'h8);
        ticks(3);
        check_irq("os_irq_sticky", 1'b1);
        check_reg("os_count_held", 2'd2, 32'd0);
        bus_write(2'd0, 32'h8);
        check_irq("os_irq_cleared", 1'b0);

        // ---------------- Auto-reload, PRESET=2 ----------------
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'hB);                 // edge N
        tick();                                 // N+1
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                check_reg("ar_count", 2'd2, ar_count[i]);
                check_irq("ar_irq", ar_irq[i]);
            end
        end
        bus_write(2'd0, 32'h0);
        ticks(4);

        // ---------------- Masked one-shot ----------------
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h1);                 // edge N
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_irq("mask_irq", 1'b0);
        end
        check_reg("mask_count", 2'd2, 32'd0);
        tick();                                 // N+5
        check_reg("mask_en_cleared", 2'd0, 32'h0);
        check_irq("mask_irq_after", 1'b0);

        // ---------------- Pause and resume ----------------
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h9);                 // edge N
        ticks(2);                               // N+2
        check_reg("pause_load", 2'd2, 32'd10);
        ticks(4);                               // N+6
        check_reg("pause_pre", 2'd2, 32'd6);
        bus_write(2'd0, 32'h8);                 // edge N+7 still decrements
        check_reg("pause_at5", 2'd2, 32'd5);
        ticks(3);
        check_reg("pause_hold", 2'd2, 32'd5);
        check_reg("pause_ctrl", 2'd0, 32'h8);
        check_irq("pause_irq", 1'b0);
        bus_write(2'd0, 32'h9);                 // edge M
        ticks(2);
        check_reg("resume_reload", 2'd2, 32'd10);
        ticks(3);
        check_reg("resume_at7", 2'd2, 32'd7);

        // ---------------- Asynchronous reset mid-count ----------------
        #2;
        rst = 1'b0;
        #1;
        check_reg("arst_ctrl", 2'd0, 32'd0);
        check_reg("arst_preset", 2'd1, 32'd0);
        check_reg("arst_count", 2'd2, 32'd0);
        check_irq("arst_irq", 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        ticks(15);
        check_irq("arst_no_irq", 1'b0);
        check_reg("arst_idle_count", 2'd2, 32'd0);
        check_reg("arst_idle_ctrl", 2'd0, 32'd0);

        // ---------------- PRESET=0 behaves as PRESET=1 ----------------
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h9);                 // edge N
        ticks(2);                               // N+2
        check_reg("p0_count", 2'd2, 32'd0);
        check_irq("p0_irq_low", 1'b0);
        tick();                                 // N+3
        check_irq("p0_irq_rise", 1'b1);
        tick();
        check_reg("p0_en_cleared", 2'd0, 32'h8);
        bus_write(2'd1, 32'd5);
        check_irq("p0_preset_wr_clears", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_timer_dev
`default_nettype wire
